// File: rtl/dpc_pkg.sv
// rtl/dpc_pkg.sv - shared DPC/CIO types and constants
package dpc_pkg;

  typedef enum logic [1:0] {
    CIO_RX_IDLE    = 2'd0,
    CIO_RX_WAIT    = 2'd1,
    CIO_RX_DELIVER = 2'd2,
    CIO_RX_HOLD    = 2'd3
  } cio_rx_state_t;

  localparam logic [7:0] ASCII_NUL      = 8'h00;
  localparam int         CIO_FIFO_DEPTH = 16;

endpackage

// File: rtl/Impulse.sv
// rtl/Impulse.sv - rising-edge detector on a level input
module Impulse (
  input  logic Clock,
  input  logic Rst_n,
  input  logic level,
  output logic pulse
);

  logic prev;

  // History resets high so a level already asserted through reset never looks like a fresh edge.
  always_ff @(negedge Clock) begin
    if (!Rst_n) prev <= 1'b1;
    else        prev <= level;
  end

  assign pulse = level & ~prev;

endmodule

// File: rtl/cio_fifo.sv
// rtl/cio_fifo.sv - synchronous byte FIFO with occupancy count
module cio_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              Clock,
  input  logic              Rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] DEPTH_CT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic              do_push;
  logic              do_pop;

  // The extra pointer bit separates full from empty; the low bits index storage.
  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == DEPTH_CT);
  assign empty   = (wr_ptr == rd_ptr);
  assign rdata   = mem[rd_ptr[ADDR_W-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(negedge Clock) begin
    if (!Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(negedge Clock) begin
    if (do_push) mem[wr_ptr[ADDR_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/cio_stdin_rx.sv
// rtl/cio_stdin_rx.sv - console input path: key capture FIFO, core delivery FSM, echo
module cio_stdin_rx
  import dpc_pkg::*;
#(
  parameter int DEPTH  = CIO_FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              Clock_1us,
  input  logic              Rst_n,
  input  logic [7:0]        key_data,
  input  logic              key_vld_i,
  input  logic              rx_req,
  output logic [7:0]        rx_data,
  output logic              rx_vld,
  output logic [7:0]        echo_data,
  output logic              echo_vld,
  output logic              view_req,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow
);

  cio_rx_state_t state, state_nxt;
  logic          key_edge;
  logic          key_event;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [7:0]    head;

  Impulse u_key_edge (
    .Clock (Clock_1us),
    .Rst_n (Rst_n),
    .level (key_vld_i),
    .pulse (key_edge)
  );

  assign key_event = key_edge && (key_data != ASCII_NUL);
  assign push      = key_event && !full;

  cio_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (8)
  ) u_fifo (
    .Clock (Clock_1us),
    .Rst_n (Rst_n),
    .push  (push),
    .wdata (key_data),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_ff @(negedge Clock_1us) begin
    if (!Rst_n) begin
      state     <= CIO_RX_IDLE;
      rx_data   <= '0;
      rx_vld    <= 1'b0;
      echo_data <= '0;
      echo_vld  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state    <= state_nxt;
      rx_vld   <= pop;
      echo_vld <= push;
      if (pop)               rx_data   <= head;
      if (push)              echo_data <= key_data;
      if (key_event && full) overflow  <= 1'b1;
    end
  end

  // HOLD waits for the core to drop its request so one request yields exactly one byte.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    view_req  = 1'b0;
    case (state)
      CIO_RX_IDLE: begin
        if (rx_req) state_nxt = empty ? CIO_RX_WAIT : CIO_RX_DELIVER;
      end
      CIO_RX_WAIT: begin
        view_req = 1'b1;
        if (!empty)      state_nxt = CIO_RX_DELIVER;
        else if (!rx_req) state_nxt = CIO_RX_IDLE;
      end
      CIO_RX_DELIVER: begin
        pop       = 1'b1;
        state_nxt = CIO_RX_HOLD;
      end
      CIO_RX_HOLD: begin
        if (!rx_req) state_nxt = CIO_RX_IDLE;
      end
      default: state_nxt = CIO_RX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cio_stdin_rx.sv
// tb/tb_cio_stdin_rx.sv - scoreboard bench for cio_stdin_rx
module tb_cio_stdin_rx;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic [7:0]        key_data  = 8'h00;
  logic              key_vld_i = 1'b0;
  logic              rx_req    = 1'b0;
  logic [7:0]        rx_data;
  logic              rx_vld;
  logic [7:0]        echo_data;
  logic              echo_vld;
  logic              view_req;
  logic [ADDR_W:0]   fifo_count;
  logic              overflow;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_q[$];
  logic [7:0] exp_echo[$];
  int         exp_ovf = 0;

  always #5 clk = ~clk;

  cio_stdin_rx #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .Clock_1us  (clk),
    .Rst_n      (rst_n),
    .key_data   (key_data),
    .key_vld_i  (key_vld_i),
    .rx_req     (rx_req),
    .rx_data    (rx_data),
    .rx_vld     (rx_vld),
    .echo_data  (echo_data),
    .echo_vld   (echo_vld),
    .view_req   (view_req),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: a key press is one event; nonzero bytes enter the queue if it has room, else overflow.
  task automatic key_down(input logic [7:0] k);
    key_data  = k;
    key_vld_i = 1'b1;
    if (k != 8'h00) begin
      if (model_q.size() < DEPTH) begin
        model_q.push_back(k);
        exp_echo.push_back(k);
      end else begin
        exp_ovf = 1;
      end
    end
  endtask

  task automatic key_up();
    key_vld_i = 1'b0;
  endtask

  task automatic press(input logic [7:0] k);
    key_down(k);
    tick();
    key_up();
    tick();
  endtask

  task automatic do_req(input int exp_lat, input string nm);
    int lat;
    lat    = 0;
    rx_req = 1'b1;
    do begin
      tick();
      lat++;
    end while (!rx_vld && lat < 20);
    check(nm, lat, exp_lat);
    rx_req = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    key_vld_i = 1'b0;
    rx_req    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    model_q.delete();
    exp_echo.delete();
    exp_ovf = 0;
    tick();
  endtask

  // Monitor: every echo and delivery strobe pops the oldest expected byte.
  task automatic monitor();
    forever begin
      @(posedge clk);
      if (echo_vld) begin
        if (exp_echo.size() == 0) check("echo_extra", echo_vld, 0);
        else check("echo_data", echo_data, exp_echo.pop_front());
      end
      if (rx_vld) begin
        if (model_q.size() == 0) check("rx_extra", rx_vld, 0);
        else check("rx_data", rx_data, model_q.pop_front());
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int         lat;
    int         v1;
    int         v2;
    logic [7:0] k;
    fork
      monitor();
    join_none

    do_reset();
    check("rst_rx_vld", rx_vld, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_echo_vld", echo_vld, 0);
    check("rst_echo_data", echo_data, 0);
    check("rst_view_req", view_req, 0);
    check("rst_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);

    // 1: long key hold is one capture
    key_down(8'h41);
    repeat (50) tick();
    key_up();
    tick();
    check("t1_count", fifo_count, 1);
    check("t1_echo_seen", exp_echo.size(), 0);

    // 2: two requests deliver in order
    do_reset();
    press(8'h31);
    press(8'h32);
    check("t2_count", fifo_count, 2);
    do_req(2, "t2_lat1");
    do_req(2, "t2_lat2");
    check("t2_count_end", fifo_count, 0);

    // 3: request on empty FIFO waits with view_req
    rx_req = 1'b1;
    tick();
    tick();
    check("t3_view_wait", view_req, 1);
    key_down(8'h5A);
    lat = 0;
    v1  = 0;
    v2  = 0;
    do begin
      tick();
      lat++;
      if (lat == 1) v1 = view_req;
      if (lat == 2) v2 = view_req;
    end while (!rx_vld && lat < 20);
    check("t3_lat", lat, 3);
    check("t3_view_capture", v1, 1);
    check("t3_view_deliver", v2, 0);
    rx_req = 1'b0;
    key_up();
    tick();
    check("t3_view_idle", view_req, 0);

    // 4: overfill with pointers already offset so storage wraps
    for (int i = 0; i < 17; i++) press(8'h40 + 8'(i));
    check("t4_count", fifo_count, 16);
    check("t4_overflow", overflow, 1);
    check("t4_echo_seen", exp_echo.size(), 0);
    for (int i = 0; i < 16; i++) do_req(2, "t4_lat");
    check("t4_count_end", fifo_count, 0);
    check("t4_overflow_sticky", overflow, 1);

    // 5: capture coincides with the delivery pop
    for (int i = 0; i < 3; i++) press(8'($urandom_range(1, 255)));
    rx_req = 1'b1;
    tick();
    key_down(8'h77);
    tick();
    check("t5_rx_vld", rx_vld, 1);
    check("t5_count", fifo_count, 3);
    rx_req = 1'b0;
    key_up();
    tick();
    for (int i = 0; i < 3; i++) do_req(2, "t5_lat");
    check("t5_count_end", fifo_count, 0);

    // 6: reset while in HOLD with entries, key held through reset
    for (int i = 0; i < 6; i++) press(8'h60 + 8'(i));
    rx_req = 1'b1;
    repeat (4) tick();
    check("t6_hold_count", fifo_count, 5);
    check("t6_hold_rx_vld", rx_vld, 0);
    rst_n     = 1'b0;
    rx_req    = 1'b0;
    key_data  = 8'h55;
    key_vld_i = 1'b1;
    tick();
    rst_n = 1'b1;
    model_q.delete();
    exp_echo.delete();
    exp_ovf = 0;
    tick();
    check("t6_count", fifo_count, 0);
    check("t6_rx_vld", rx_vld, 0);
    check("t6_overflow", overflow, 0);
    check("t6_view_req", view_req, 0);
    repeat (3) tick();
    check("t6_held_key", fifo_count, 0);
    key_up();
    tick();
    press(8'h66);
    do_req(2, "t6_idle_lat");

    // Randomized mix of presses (some NUL) and requests
    do_reset();
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 9) < 6) begin
        k = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        key_down(k);
        repeat ($urandom_range(1, 3)) tick();
        key_up();
        tick();
      end else if (model_q.size() > 0) begin
        do_req(2, "rand_lat");
      end else begin
        tick();
      end
      check("rand_count", fifo_count, model_q.size());
      check("rand_overflow", overflow, exp_ovf);
    end
    while (model_q.size() > 0) do_req(2, "drain_lat");
    check("final_count", fifo_count, 0);
    check("final_echo_seen", exp_echo.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
